// File: rtl/disp_pkg.sv
// Shared types and constants for the calculator display controller.
// Optional leading-zero blanking is enabled by defining DISP_CTRL_LZB_EN.
package disp_pkg;

  localparam int unsigned DISP_DIGITS = 4;
  localparam int unsigned DISP_BCD_W  = 16;
  localparam int unsigned DISP_MAX    = 9999;
  localparam logic [DISP_BCD_W-1:0] DISP_ERR_BCD = 16'hEEEE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_COMMIT
  } disp_state_e;

  // Blank a digit when it and every more-significant digit are zero; digit 0 always shown
  function automatic logic [DISP_DIGITS-1:0] lzb_mask(input logic [DISP_BCD_W-1:0] bcd);
    logic [DISP_DIGITS-1:0] m;
    m    = '0;
    m[3] = (bcd[15:12] == 4'd0);
    m[2] = m[3] && (bcd[11:8] == 4'd0);
    m[1] = m[2] && (bcd[7:4] == 4'd0);
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per step.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int unsigned DW = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DW-1:0]         bin_in,
  input  logic                  step,
  output logic [DISP_BCD_W-1:0] bcd,
  output logic                  last_c
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic [DW-1:0]         sh_q;
  logic [CW-1:0]         cnt_q;
  logic [DISP_BCD_W-1:0] adj_c;

  // Add-3 correction on every nibble that would overflow past 9 after the shift
  always_comb begin
    adj_c = bcd;
    for (int i = 0; i < int'(DISP_DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load clears the accumulator; each step shifts the next value MSB into the BCD register
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q  <= '0;
      bcd   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sh_q  <= bin_in;
      bcd   <= '0;
      cnt_q <= '0;
    end else if (step) begin
      bcd   <= DISP_BCD_W'({adj_c, sh_q[DW-1]});
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // High while the final step is pending
  assign last_c = (cnt_q == CW'(DW - 1));

endmodule

// File: rtl/disp_ctrl.sv
// Display controller: request arbiter, BCD conversion sequencer, commit registers, scan schedule.
// Leading-zero blanking is enabled by defining DISP_CTRL_LZB_EN.
module disp_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DW       = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ent_req,
  input  logic [DW-1:0]          ent_val,
  output logic                   ent_ack,
  input  logic                   res_req,
  input  logic [DW-1:0]          res_val,
  input  logic                   res_neg,
  output logic                   res_ack,
  output logic                   busy,
  output logic [DISP_BCD_W-1:0]  disp_bcd,
  output logic [DISP_DIGITS-1:0] disp_blank,
  output logic                   disp_neg,
  output logic                   disp_err,
  output logic [1:0]             scan_idx,
  output logic                   scan_tick
);

  localparam int unsigned PW = $clog2(SCAN_DIV);

`ifdef DISP_CTRL_LZB_EN
  localparam logic [DISP_DIGITS-1:0] BLANK_RST = 4'b1110;
`else
  localparam logic [DISP_DIGITS-1:0] BLANK_RST = 4'b0000;
`endif

  disp_state_e           state_q, state_d;
  logic                  grant_res_c, grant_ent_c, load_c, step_c, last_c;
  logic [DW-1:0]         sel_val_c;
  logic [DISP_BCD_W-1:0] bcd;
  logic                  neg_q, err_q, zero_q;
  logic [DISP_DIGITS-1:0] blank_q;
  logic [PW-1:0]         presc_q;

  assign sel_val_c = grant_res_c ? res_val : ent_val;

  bin2bcd_seq #(.DW(DW)) u_b2b (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .bin_in (sel_val_c),
    .step   (step_c),
    .bcd    (bcd),
    .last_c (last_c)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state and grant decode; result requester wins ties
  always_comb begin
    state_d     = state_q;
    grant_res_c = 1'b0;
    grant_ent_c = 1'b0;
    load_c      = 1'b0;
    step_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (res_req) begin
          grant_res_c = 1'b1;
          load_c      = 1'b1;
          state_d     = ST_SHIFT;
        end else if (ent_req) begin
          grant_ent_c = 1'b1;
          load_c      = 1'b1;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step_c = 1'b1;
        if (last_c) state_d = ST_BLANK;
      end
      ST_BLANK:  state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Ack pulses and busy flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_ack <= 1'b0;
      res_ack <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ent_ack <= grant_ent_c;
      res_ack <= grant_res_c;
      if (load_c)                    busy <= 1'b1;
      else if (state_q == ST_COMMIT) busy <= 1'b0;
    end
  end

  // Capture sign and range attributes of the granted value
  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (load_c) begin
      neg_q  <= grant_res_c & res_neg;
      err_q  <= (32'(sel_val_c) > DISP_MAX);
      zero_q <= (sel_val_c == '0);
    end
  end

  // Blank mask derived once the conversion result is final
  always_ff @(posedge clk) begin
    if (!rst) begin
      blank_q <= BLANK_RST;
    end else if (state_q == ST_BLANK) begin
`ifdef DISP_CTRL_LZB_EN
      blank_q <= lzb_mask(bcd);
`else
      blank_q <= '0;
`endif
    end
  end

  // Display outputs update together, only on commit
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_bcd   <= '0;
      disp_blank <= BLANK_RST;
      disp_neg   <= 1'b0;
      disp_err   <= 1'b0;
    end else if (state_q == ST_COMMIT) begin
      disp_bcd   <= err_q ? DISP_ERR_BCD : bcd;
      disp_blank <= err_q ? '0 : blank_q;
      disp_neg   <= neg_q & ~zero_q & ~err_q;
      disp_err   <= err_q;
    end
  end

  // Free-running digit scan prescaler and index
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q   <= '0;
      scan_idx  <= '0;
      scan_tick <= 1'b0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q   <= '0;
      scan_tick <= 1'b1;
      scan_idx  <= (scan_idx == 2'(DIGITS - 1)) ? 2'd0 : scan_idx + 2'd1;
    end else begin
      presc_q   <= presc_q + PW'(1);
      scan_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disp_ctrl.sv
// Self-checking bench for disp_ctrl: directed cases plus randomized updates against a decimal model.
module tb_disp_ctrl;

  localparam int SD = 4;

  logic        clk, rst;
  logic        ent_req, res_req, res_neg;
  logic [13:0] ent_val, res_val;
  logic        ent_ack, res_ack, busy, disp_neg, disp_err, scan_tick;
  logic [15:0] disp_bcd;
  logic [3:0]  disp_blank;
  logic [1:0]  scan_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] cur_bcd;
  logic [3:0]  cur_blank;
  logic        cur_neg, cur_err;

`ifdef DISP_CTRL_LZB_EN
  localparam logic [3:0] RST_BLANK = 4'b1110;
`else
  localparam logic [3:0] RST_BLANK = 4'b0000;
`endif

  disp_ctrl #(.SCAN_DIV(SD), .DIGITS(4), .DW(14)) dut (
    .clk        (clk),
    .rst        (rst),
    .ent_req    (ent_req),
    .ent_val    (ent_val),
    .ent_ack    (ent_ack),
    .res_req    (res_req),
    .res_val    (res_val),
    .res_neg    (res_neg),
    .res_ack    (res_ack),
    .busy       (busy),
    .disp_bcd   (disp_bcd),
    .disp_blank (disp_blank),
    .disp_neg   (disp_neg),
    .disp_err   (disp_err),
    .scan_idx   (scan_idx),
    .scan_tick  (scan_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges seen since reset release
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [15:0] m_bcd(input int v);
    logic [15:0] r;
    int p;
    if (v > 9999) return 16'hEEEE;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] m_blank(input int v);
    logic [3:0] b;
    int p;
    b = '0;
`ifdef DISP_CTRL_LZB_EN
    p = 10;
    for (int i = 1; i < 4; i++) begin
      b[i] = (v <= 9999) && (v < p);
      p = p * 10;
    end
`else
    p = v;
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then sample and check the scan schedule against elapsed cycles
  task automatic step();
    @(posedge clk);
    #1;
    chk("scan_tick", 32'(scan_tick), 32'((cyc != 0) && (cyc % SD == 0)));
    chk("scan_idx", 32'(scan_idx), 32'((cyc / SD) % 4));
  endtask

  task automatic chk_disp(input string tag);
    chk({tag, "_bcd"},   32'(disp_bcd),   32'(cur_bcd));
    chk({tag, "_blank"}, 32'(disp_blank), 32'(cur_blank));
    chk({tag, "_neg"},   32'(disp_neg),   32'(cur_neg));
    chk({tag, "_err"},   32'(disp_err),   32'(cur_err));
  endtask

  // Full update: request granted at the next edge, display changes 16 edges later
  task automatic conv(input bit is_res, input int v, input bit neg);
    if (is_res) begin
      res_req = 1'b1; res_val = 14'(v); res_neg = neg;
    end else begin
      ent_req = 1'b1; ent_val = 14'(v);
    end
    step();
    chk("ack_grant", 32'(is_res ? res_ack : ent_ack), 32'd1);
    chk("ack_other", 32'(is_res ? ent_ack : res_ack), 32'd0);
    chk("busy_rise", 32'(busy), 32'd1);
    if (is_res) res_req = 1'b0; else ent_req = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("busy_hold", 32'(busy), 32'd1);
      chk("ack_quiet", 32'({ent_ack, res_ack}), 32'd0);
      chk_disp("hold");
    end
    step();
    cur_bcd   = m_bcd(v);
    cur_blank = m_blank(v);
    cur_neg   = is_res && neg && (v != 0) && (v <= 9999);
    cur_err   = (v > 9999);
    chk("busy_fall", 32'(busy), 32'd0);
    chk_disp("commit");
  endtask

  initial begin
    int v, gap;
    bit r, n;
    rst = 1'b0; ent_req = 1'b0; res_req = 1'b0; res_neg = 1'b0;
    ent_val = '0; res_val = '0;
    cur_bcd = '0; cur_blank = RST_BLANK; cur_neg = 1'b0; cur_err = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({ent_ack, res_ack}), 32'd0);
    chk_disp("rst");
    step();

    conv(1'b0, 42, 1'b0);

    ent_req = 1'b1; ent_val = 14'd7;
    conv(1'b1, 1234, 1'b1);
    chk("ent_pending_noack", 32'(ent_ack), 32'd0);
    conv(1'b0, 7, 1'b0);

    conv(1'b1, 12000, 1'b1);
    conv(1'b1, 0, 1'b1);
    conv(1'b1, 9999, 1'b1);
    conv(1'b0, 10000, 1'b0);
    conv(1'b0, 5, 1'b0);
    conv(1'b1, 100, 1'b0);

    for (int k = 0; k < 24; k++) begin
      r = 1'($urandom_range(0, 1));
      n = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 16383));
        1:       v = int'($urandom_range(0, 99));
        default: v = int'($urandom_range(0, 9999));
      endcase
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      conv(r, v, n);
    end

    // Reset partway through a conversion aborts it
    res_req = 1'b1; res_val = 14'd9999; res_neg = 1'b0;
    step();
    chk("abort_ack", 32'(res_ack), 32'd1);
    res_req = 1'b0;
    repeat (7) step();
    rst = 1'b0;
    step();
    cur_bcd = '0; cur_blank = RST_BLANK; cur_neg = 1'b0; cur_err = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_acks", 32'({ent_ack, res_ack}), 32'd0);
    chk_disp("abort");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_abort_acks", 32'({ent_ack, res_ack, busy}), 32'd0);
    end
    chk_disp("post_abort");

    conv(1'b1, 808, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_ctrl.md
# disp_ctrl

Display controller for the calculator's 4-digit multiplexed 7-segment output. It shares the digit buffer between two requesters, keypad entry and ALU result, with fixed priority. It converts the granted binary value to BCD sequentially (double-dabble) and computes leading-zero blanking. It also generates the digit-scan schedule (index plus strobe) consumed by the segment scanner.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot; legal range 2..2^20.
- `DIGITS`, default 4: digit count; fixed at 4 in this revision.
- `DW`, default 14: binary value width; 2^14 covers 0..9999.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-low.
- `ent_req`  in  1: keypad entry update request; held until ack.
- `ent_val`  in  14: entry value, unsigned.
- `ent_ack`  out  1: one-cycle grant pulse for entry.
- `res_req`  in  1: ALU result update request; held until ack.
- `res_val`  in  14: result magnitude.
- `res_neg`  in  1: result sign.
- `res_ack`  out  1: one-cycle grant pulse for result.
- `busy`  out  1: conversion in progress.
- `disp_bcd`  out  16: four BCD digits; [3:0] is the least significant digit.
- `disp_blank`  out  4: per-digit blank flag.
- `disp_neg`  out  1: minus-sign enable.
- `disp_err`  out  1: overflow indication.
- `scan_idx`  out  2: digit currently being driven.
- `scan_tick`  out  1: one-cycle pulse when `scan_idx` advances.

## Operation
- FSM states: IDLE, SHIFT, BLANK, COMMIT.
- **IDLE:** requests are sampled each edge.
  - `res_req` has priority over `ent_req`.
  - The loser stays pending and is granted when the FSM next returns to IDLE.
  - On a grant: capture value and sign (sign is 0 for entry), pulse the matching ack for the next cycle only, set `busy`, go to SHIFT.
- **SHIFT:** runs exactly DW=14 iterations.
  - Each iteration: add 3 to every BCD nibble ≥5, then shift left by 1, bringing in the next value MSB.
- **BLANK:** derive the blank mask.
  - A digit is blanked if it and all more-significant digits are 0.
  - Digit 0 is never blanked.
- **COMMIT:** register `disp_bcd`, `disp_blank`, `disp_neg`, `disp_err` together, clear `busy`, return to IDLE.
- **Overflow:** a captured value >9999 sets `disp_err=1`, `disp_bcd=16'hEEEE`, `disp_blank=0`, `disp_neg=0`. Conversion still runs full length so latency is constant.
- **Negative zero:** `res_neg=1` with value 0 gives `disp_neg=0`.
- **Requests while busy:** ignored and not acked; they remain pending.
- Display outputs hold their last committed values until the next COMMIT; no partial updates.
- **Scan schedule** (free-running, independent of the FSM):
  - Prescaler counts 0..SCAN_DIV-1.
  - At wrap, `scan_tick`=1 for one cycle and `scan_idx` increments mod 4 (3→0).
- **Reset values** (also applied on `rst=0` mid-conversion, which aborts the conversion without an ack):
  - FSM IDLE, `busy=0`, `ent_ack=0`, `res_ack=0`.
  - `disp_bcd=0`, `disp_blank=4'b1110`, `disp_neg=0`, `disp_err=0`.
  - `scan_idx=0`, `scan_tick=0`, prescaler=0.

## Timing
- Request sampled at edge T: ack is high during cycle T..T+1, `busy` rises at T.
- SHIFT occupies edges T+1..T+14, BLANK edge T+15.
- Display outputs and `busy=0` take effect at edge T+16.
- Earliest next grant is at edge T+17, so back-to-back throughput is one update per 17 cycles.
- Simultaneous requests at T: `res_ack` at T+1; `ent_ack` at T+18 if `ent_req` is still held.
- `scan_tick` period is exactly SCAN_DIV cycles; the first tick occurs SCAN_DIV cycles after reset release.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `DISP_CTRL_LZB_EN`.
- Defined: leading-zero blanking as described.
- Undefined: BLANK state still exists (latency unchanged) but `disp_blank` is always `4'b0000` and the reset value is `4'b0000`.

## Structure
- Package `disp_pkg` holds:
  - FSM state enum.
  - `DISP_DIGITS=4`, `DISP_BCD_W=16`.
  - `DISP_MAX=9999`.
  - `DISP_ERR_BCD=16'hEEEE`.
- Sub-module `bin2bcd_seq` holds the iterative double-dabble datapath (load, step, done count). `disp_ctrl` contains the arbiter, FSM, commit registers and scan prescaler.

## Test plan
- Reset, then `ent_req` with 42 → `ent_ack` at T+1; at T+16, `disp_bcd=16'h0042`, `disp_blank=4'b1100`, `disp_err=0`.
- `res_req` (val 1234, neg 1) and `ent_req` (7) at the same edge → `res_ack` first, shows 1234 with `disp_neg=1`; then `ent_ack` at T+18, shows 7 with `disp_blank=4'b1110`.
- `res_val`=12000 → `disp_bcd=16'hEEEE`, `disp_err=1`, `disp_blank=0`; `res_val`=0 with `res_neg=1` → `disp_neg=0`, `disp_bcd=0`.
- Deassert `rst` at T+8 of a conversion of 9999 → all outputs return to reset values, no ack, and the old display is not updated.
- SCAN_DIV=4 → `scan_tick` every 4 cycles, `scan_idx` sequence 0,1,2,3,0, unaffected by concurrent conversions.
- Build without `DISP_CTRL_LZB_EN`, value 5 → `disp_blank=4'b0000`, latency still 16.
